// File: rtl/uart_out_tx_if.sv
// Byte write request and serial status bundle for uart_out_tx.
// master drives the CPU-side write; slave is the transmitter.
interface uart_out_tx_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic                        wr_req;
  logic [7:0]                  wr_data;
  logic                        uart_txd;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        overflow;

  modport master (
    output wr_req, wr_data,
    input  uart_txd, busy, fifo_count, overflow
  );

  modport slave (
    input  wr_req, wr_data,
    output uart_txd, busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart_out_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; start bit 2 cycles after the synced write push.
// No backpressure: pushes into a full FIFO are dropped and flagged by sticky overflow.
module uart_out_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_out_tx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             s1, s2, s3;
  logic             push, do_push, pop, full;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow_q;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             txd, txd_n;

  // wr_req comes from the slow CPU clock: two sync flops, then edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.wr_req;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push    = s2 & ~s3;
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (!do_push && pop) count <= count - CW'(1);
      if (push && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      txd   <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
    // Line level is registered from the next state so txd changes with the state.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  assign bus.uart_txd   = txd;
  assign bus.busy       = (state != IDLE);
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
endmodule
